// File: rtl/rng_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rng_share_ctrl
// Purpose  : Seeds, warms up and time-shares one external 23-bit Fibonacci
//            LFSR among N_REQ workers. Each LFSR byte goes to at most one
//            worker, chosen by a round-robin arbiter. The block also counts
//            the draws made since the last start.
// Ports    : clk        - single clock, rising edge
//            rst        - synchronous active-high reset
//            start      - 1-cycle pulse: latch seed_in, (re)seed LFSR, run
//            stop       - 1-cycle pulse: end run, return to IDLE
//            seed_in    - seed sampled on start (0 is replaced by 1)
//            req        - level request per worker, held until its gnt
//            gnt        - one-hot 1-cycle grant pulse
//            rnd_data   - random byte for the granted worker, valid with gnt
//            rnd_valid  - OR of gnt
//            ready      - high only while serving requests (RUN)
//            draw_cnt   - grants issued since the last start, saturating
//            lfsr_rst_n - registered active-low reset to the LFSR
//            lfsr_seed  - registered seed to the LFSR
//            lfsr_out   - LFSR output byte, advances every cycle
// Revision : 1.0 - initial release
// ============================================================================
module rng_share_ctrl #(
    parameter int N_REQ  = 4,
    parameter int WARMUP = 32,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [22:0]        seed_in,
    input  logic [N_REQ-1:0]   req,
    output logic [N_REQ-1:0]   gnt,
    output logic [7:0]         rnd_data,
    output logic               rnd_valid,
    output logic               ready,
    output logic [CNT_W-1:0]   draw_cnt,
    output logic               lfsr_rst_n,
    output logic [22:0]        lfsr_seed,
    input  logic [7:0]         lfsr_out
);

    localparam int PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WCNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SEED   = 2'd1;
    localparam logic [1:0] c_WARMUP = 2'd2;
    localparam logic [1:0] c_RUN    = 2'd3;

    localparam logic [WCNT_W-1:0] c_WARM_LAST = WCNT_W'(WARMUP - 1);
    localparam logic [PTR_W-1:0]  c_PTR_LAST  = PTR_W'(N_REQ - 1);
    localparam logic [PTR_W:0]    c_N_REQ     = (PTR_W+1)'(N_REQ);

    logic [1:0]        r_state;
    logic              r_seed_cnt;
    logic [WCNT_W-1:0] r_warm_cnt;
    logic [N_REQ-1:0]  r_gnt;
    logic              r_valid;
    logic [7:0]        r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_lfsr_rst_n;
    logic [22:0]       r_seed;
    logic [PTR_W-1:0]  r_ptr;

    logic [N_REQ-1:0]  w_elig;
    logic              w_found;
    logic [PTR_W-1:0]  w_sel;
    logic [PTR_W:0]    w_cand;
    logic [N_REQ-1:0]  w_gnt_next;
    logic [PTR_W-1:0]  w_ptr_next;

    // Round-robin search starting at r_ptr. The worker granted last cycle is
    // masked out because its req is still high while it sees the gnt pulse.
    always_comb begin
        w_elig     = req & ~r_gnt;
        w_found    = 1'b0;
        w_sel      = '0;
        w_cand     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_cand = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_cand >= c_N_REQ) begin
                w_cand = w_cand - c_N_REQ;
            end
            if (!w_found && w_elig[w_cand[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_cand[PTR_W-1:0];
            end
        end
        w_gnt_next        = '0;
        w_gnt_next[w_sel] = 1'b1;
        w_ptr_next        = (w_sel == c_PTR_LAST) ? '0 : w_sel + PTR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_seed_cnt   <= 1'b0;
            r_warm_cnt   <= '0;
            r_gnt        <= '0;
            r_valid      <= 1'b0;
            r_data       <= 8'h00;
            r_cnt        <= '0;
            r_lfsr_rst_n <= 1'b0;
            r_seed       <= 23'h1;
            r_ptr        <= '0;
        end else begin
            // Grants are pulses; only a RUN-state grant below re-asserts them.
            r_gnt   <= '0;
            r_valid <= 1'b0;
            if (stop) begin
                // stop has priority over a simultaneous start
                r_state      <= c_IDLE;
                r_lfsr_rst_n <= 1'b0;
            end else if (start) begin
                // An all-zero seed would lock the LFSR, so substitute 1.
                r_seed       <= (seed_in == 23'h0) ? 23'h1 : seed_in;
                r_cnt        <= '0;
                r_state      <= c_SEED;
                r_seed_cnt   <= 1'b0;
                r_lfsr_rst_n <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_lfsr_rst_n <= 1'b0;
                    end
                    c_SEED: begin
                        // Hold the LFSR in reset for two cycles so it loads the seed.
                        if (r_seed_cnt) begin
                            r_state      <= c_WARMUP;
                            r_lfsr_rst_n <= 1'b1;
                            r_warm_cnt   <= '0;
                        end else begin
                            r_seed_cnt <= 1'b1;
                        end
                    end
                    c_WARMUP: begin
                        if (r_warm_cnt == c_WARM_LAST) begin
                            r_state <= c_RUN;
                        end else begin
                            r_warm_cnt <= r_warm_cnt + WCNT_W'(1);
                        end
                    end
                    c_RUN: begin
                        if (w_found) begin
                            r_gnt   <= w_gnt_next;
                            r_valid <= 1'b1;
                            r_data  <= lfsr_out;
                            r_ptr   <= w_ptr_next;
                            if (r_cnt != {CNT_W{1'b1}}) begin
                                r_cnt <= r_cnt + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= c_IDLE;
                    end
                endcase
            end
        end
    end

    assign gnt        = r_gnt;
    assign rnd_data   = r_data;
    assign rnd_valid  = r_valid;
    assign ready      = (r_state == c_RUN);
    assign draw_cnt   = r_cnt;
    assign lfsr_rst_n = r_lfsr_rst_n;
    assign lfsr_seed  = r_seed;

endmodule
`default_nettype wire

// File: tb/tb_rng_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_rng_share_ctrl
// Purpose  : Self-checking bench for rng_share_ctrl with an attached
//            reference LFSR (x^23 + x^18 + 1) and a grant scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rng_share_ctrl;

    localparam int N_REQ  = 4;
    localparam int WARMUP = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              stop;
    logic [22:0]       seed_in;
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  gnt;
    logic [7:0]        rnd_data;
    logic              rnd_valid;
    logic              ready;
    logic [CNT_W-1:0]  draw_cnt;
    logic              lfsr_rst_n;
    logic [22:0]       lfsr_seed;
    logic [7:0]        lfsr_out;

    rng_share_ctrl #(
        .N_REQ  (N_REQ),
        .WARMUP (WARMUP),
        .CNT_W  (CNT_W)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .seed_in    (seed_in),
        .req        (req),
        .gnt        (gnt),
        .rnd_data   (rnd_data),
        .rnd_valid  (rnd_valid),
        .ready      (ready),
        .draw_cnt   (draw_cnt),
        .lfsr_rst_n (lfsr_rst_n),
        .lfsr_seed  (lfsr_seed),
        .lfsr_out   (lfsr_out)
    );

    always #5 clk = ~clk;

    // Reference Fibonacci LFSR driven by the controller.
    logic [22:0] env_lfsr;
    always @(posedge clk) begin
        if (!lfsr_rst_n) env_lfsr <= lfsr_seed;
        else             env_lfsr <= {env_lfsr[21:0], env_lfsr[22] ^ env_lfsr[17]};
    end
    assign lfsr_out = env_lfsr[7:0];

    typedef struct {
        logic [N_REQ-1:0] g;
        logic [7:0]       d;
        logic [CNT_W-1:0] c;
    } exp_t;

    exp_t q_exp[$];

    int n_checks = 0;
    int n_errors = 0;

    // Arbiter model state
    int               m_ptr  = 0;
    logic [N_REQ-1:0] m_gnt  = '0;
    logic [7:0]       m_data = 8'h00;
    logic [CNT_W-1:0] m_cnt  = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive req for n RUN cycles; push the modelled result before each edge,
    // pop and compare it after the edge.
    task automatic run_cycles(input int n, input logic [N_REQ-1:0] pat);
        exp_t e;
        logic [N_REQ-1:0] elig;
        int idx;
        bit found;
        for (int c = 0; c < n; c++) begin
            req   = pat;
            elig  = pat & ~m_gnt;
            found = 0;
            idx   = 0;
            for (int k = 0; k < N_REQ; k++) begin
                if (!found && elig[(m_ptr + k) % N_REQ]) begin
                    found = 1;
                    idx   = (m_ptr + k) % N_REQ;
                end
            end
            if (found) begin
                m_gnt  = '0;
                m_gnt[idx] = 1'b1;
                m_data = lfsr_out;
                m_ptr  = (idx + 1) % N_REQ;
                if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
            end else begin
                m_gnt = '0;
            end
            e.g = m_gnt;
            e.d = m_data;
            e.c = m_cnt;
            q_exp.push_back(e);
            step();
            e = q_exp.pop_front();
            check("gnt", 32'(gnt), 32'(e.g));
            check("rnd_valid", 32'(rnd_valid), 32'(|e.g));
            check("rnd_data", 32'(rnd_data), 32'(e.d));
            check("draw_cnt", 32'(draw_cnt), 32'(e.c));
            check("ready_run", 32'(ready), 32'd1);
        end
    endtask

    // Pulse start, then time the seed and warm-up phases.
    task automatic do_start(input logic [22:0] s, input logic [N_REQ-1:0] pat);
        int n_low;
        int n_warm;
        logic [22:0] exp_seed;
        exp_seed = (s == 23'h0) ? 23'h1 : s;
        req     = pat;
        seed_in = s;
        start   = 1'b1;
        step();
        start   = 1'b0;
        m_gnt   = '0;
        m_cnt   = '0;
        check("seed_latched", 32'(lfsr_seed), 32'(exp_seed));
        check("ready_drop", 32'(ready), 32'd0);
        check("cnt_clear", 32'(draw_cnt), 32'd0);
        n_low = 0;
        while (!lfsr_rst_n && n_low < 10) begin
            check("gnt_seed", 32'(gnt), 32'd0);
            n_low++;
            step();
        end
        check("lfsr_rst_low_cycles", 32'(n_low), 32'd2);
        n_warm = 0;
        while (!ready && n_warm < 50) begin
            check("gnt_warm", 32'(gnt), 32'd0);
            check("lfsr_rst_n_warm", 32'(lfsr_rst_n), 32'd1);
            n_warm++;
            step();
        end
        check("warmup_cycles", 32'(n_warm), 32'(WARMUP));
    endtask

    initial begin
        logic [7:0] a;
        rst     = 1'b1;
        start   = 1'b0;
        stop    = 1'b0;
        seed_in = 23'h0;
        req     = '0;
        step();
        step();
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(rnd_valid), 32'd0);
        check("rst_data", 32'(rnd_data), 32'd0);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_cnt", 32'(draw_cnt), 32'd0);
        check("rst_lfsr_rst_n", 32'(lfsr_rst_n), 32'd0);
        check("rst_seed", 32'(lfsr_seed), 32'd1);
        rst = 1'b0;
        step();

        // Seed 1, full contention: 0,1,2,3,... and draw_cnt saturation at 15
        do_start(23'h1, 4'b1111);
        run_cycles(20, 4'b1111);

        // Lone requester: grant every other cycle, then pointer moves past it
        run_cycles(8, 4'b0100);
        run_cycles(3, 4'b1111);

        // Reseed from RUN with zero seed while requests are pending
        do_start(23'h0, 4'b1111);
        a = lfsr_out;
        run_cycles(6, 4'b1111);
        check("lfsr_moving", 32'(lfsr_out != a), 32'd1);

        // start+stop together in RUN: stop wins, block stays idle
        req   = 4'b1111;
        start = 1'b1;
        stop  = 1'b1;
        seed_in = 23'h55;
        step();
        start = 1'b0;
        stop  = 1'b0;
        check("ss_ready", 32'(ready), 32'd0);
        check("ss_gnt", 32'(gnt), 32'd0);
        check("ss_lfsr_rst_n", 32'(lfsr_rst_n), 32'd0);
        for (int i = 0; i < 4; i++) step();
        check("ss_idle_lfsr_rst_n", 32'(lfsr_rst_n), 32'd0);
        check("ss_idle_ready", 32'(ready), 32'd0);
        m_gnt = '0;

        // Fresh run, then reset mid-run with all requests high
        do_start(23'h2a5c3, 4'b1011);
        run_cycles(5, 4'b1011);
        req = 4'b1111;
        rst = 1'b1;
        step();
        check("mid_rst_gnt", 32'(gnt), 32'd0);
        check("mid_rst_valid", 32'(rnd_valid), 32'd0);
        check("mid_rst_ready", 32'(ready), 32'd0);
        check("mid_rst_cnt", 32'(draw_cnt), 32'd0);
        check("mid_rst_lfsr_rst_n", 32'(lfsr_rst_n), 32'd0);
        check("mid_rst_seed", 32'(lfsr_seed), 32'd1);
        step();
        rst = 1'b0;
        m_ptr  = 0;
        m_gnt  = '0;
        m_data = 8'h00;
        m_cnt  = '0;
        step();
        check("post_rst_gnt", 32'(gnt), 32'd0);

        // After reset the pointer restarts at worker 0
        do_start(23'h7, 4'b1111);
        run_cycles(5, 4'b1111);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
